// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, functs, FSM states,
// ALU operation codes, PC source and register destination selects.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REG    = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    typedef struct packed {
        logic       j;
        logic       jal;
        logic       jr;
        logic       halt;
        logic       beq;
        logic       bne;
        logic       lw;
        logic       sw;
        logic       alu;
        logic       imm;
        logic       sll;
        logic       ext;
        logic [2:0] alu_op;
    } cls_t;

endpackage

// File: rtl/mcu_decode.sv
// Instruction classifier: turns op/func into class flags plus the ALU operation
// and operand-select hints used by the EXE state.
module mcu_decode
    import mcu_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] func,
    output cls_t            cls
);

    always_comb begin
        cls = '0;
        if (op == OP_W'(OP_RTYPE)) begin
            case (func)
                OP_W'(FN_JR):  cls.jr = 1'b1;
                OP_W'(FN_ADD): begin cls.alu = 1'b1; cls.alu_op = ALU_ADD; end
                OP_W'(FN_SUB): begin cls.alu = 1'b1; cls.alu_op = ALU_SUB; cls.ext = 1'b1; end
                OP_W'(FN_AND): begin cls.alu = 1'b1; cls.alu_op = ALU_AND; end
                OP_W'(FN_OR):  begin cls.alu = 1'b1; cls.alu_op = ALU_OR; end
                OP_W'(FN_SLL): begin cls.alu = 1'b1; cls.alu_op = ALU_SLL; cls.sll = 1'b1; end
                default: ;
            endcase
        end else begin
            case (op)
                OP_W'(OP_J):    cls.j    = 1'b1;
                OP_W'(OP_JAL):  cls.jal  = 1'b1;
                OP_W'(OP_HALT): cls.halt = 1'b1;
                OP_W'(OP_BEQ):  cls.beq  = 1'b1;
                OP_W'(OP_BNE):  cls.bne  = 1'b1;
                OP_W'(OP_LW):   cls.lw   = 1'b1;
                OP_W'(OP_SW):   cls.sw   = 1'b1;
                OP_W'(OP_ADDI): begin cls.alu = 1'b1; cls.imm = 1'b1; cls.ext = 1'b1; cls.alu_op = ALU_ADD; end
                OP_W'(OP_ORI):  begin cls.alu = 1'b1; cls.imm = 1'b1; cls.alu_op = ALU_OR; end
                OP_W'(OP_SLTI): begin cls.alu = 1'b1; cls.imm = 1'b1; cls.ext = 1'b1; cls.alu_op = ALU_SLT; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle processor controller: IF/ID/EXE/MEM/WB/HALT state machine with
// Moore/Mealy datapath strobes decoded from state, instruction class and flags.
module multi_cycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OP_W        = 6,
    parameter int ALUOP_W     = 3,
    parameter int MEM_WAIT_EN = 1
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic [OP_W-1:0]    func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCWre,
    output logic               IRWre,
    output logic               InsMemRW,
    output logic               RegWre,
    output logic               ExtSel,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               mRD,
    output logic               mWR,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegDst,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               halted
);

    state_t     cur;
    state_t     nxt;
    cls_t       cls;
    logic [2:0] alu_code;
    logic       mem_done;

    mcu_decode #(.OP_W(OP_W)) u_decode (
        .op   (op),
        .func (func),
        .cls  (cls)
    );

    assign mem_done = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
    assign state    = cur;
    assign ALUOp    = ALUOP_W'(alu_code);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) cur <= S_IF;
        else        cur <= nxt;
    end

    always_comb begin
        nxt       = S_IF;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        RegWre    = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        PCSrc     = PC_NEXT;
        RegDst    = RD_RA;
        alu_code  = ALU_ADD;
        halted    = 1'b0;
        case (cur)
            S_IF: begin
                IRWre    = 1'b1;
                InsMemRW = 1'b1;
                nxt      = S_ID;
            end
            S_ID: begin
                if (cls.j || cls.jal) begin
                    PCWre  = 1'b1;
                    PCSrc  = PC_JUMP;
                    RegWre = cls.jal;
                end else if (cls.jr) begin
                    PCWre = 1'b1;
                    PCSrc = PC_REG;
                end else if (cls.halt) begin
                    nxt = S_HALT;
                end else if (cls.beq || cls.bne || cls.lw || cls.sw || cls.alu) begin
                    nxt = S_EXE;
                end else begin
                    // Unrecognised instruction retires as a NOP.
                    PCWre = 1'b1;
                end
            end
            S_EXE: begin
                if (cls.beq || cls.bne) begin
                    alu_code = ALU_SUB;
                    PCWre    = 1'b1;
                    if ((cls.beq && zero) || (cls.bne && !zero)) PCSrc = PC_BRANCH;
                end else if (cls.lw || cls.sw) begin
                    ExtSel  = 1'b1;
                    ALUSrcB = 1'b1;
                    nxt     = S_MEM;
                end else begin
                    alu_code = cls.alu_op;
                    ALUSrcA  = cls.sll;
                    ALUSrcB  = cls.imm;
                    ExtSel   = cls.ext;
                    nxt      = S_WB;
                end
            end
            S_MEM: begin
                mRD = cls.lw;
                mWR = cls.sw;
                if (!mem_done && (cls.lw || cls.sw)) begin
                    nxt = S_MEM;
                end else if (cls.lw) begin
                    nxt = S_WB;
                end else begin
                    PCWre = 1'b1;
                end
            end
            S_WB: begin
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                WrRegDSrc = 1'b1;
                DBDataSrc = cls.lw;
                RegDst    = (cls.lw || cls.imm) ? RD_RT : RD_RD;
            end
            S_HALT: begin
                halted = 1'b1;
                nxt    = S_HALT;
            end
            default: nxt = S_IF;
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction expected traces built from
// instruction semantics, driven cycle by cycle with randomized flags and waits.
module tb_multi_cycle_control_unit;

    logic       CLK = 1'b0;
    logic       Reset;
    logic [5:0] op, func;
    logic       zero, mem_ready;
    logic       PCWre, IRWre, InsMemRW, RegWre, ExtSel, ALUSrcA, ALUSrcB;
    logic       mRD, mWR, DBDataSrc, WrRegDSrc, halted;
    logic [1:0] PCSrc, RegDst;
    logic [2:0] ALUOp, state;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0] st;
        logic       halted, pcwre, irwre, insmem, regwre, extsel, srca, srcb;
        logic       mrd, mwr, dbsrc, wrsrc;
        logic [1:0] pcsrc, regdst;
        logic [2:0] aluop;
    } outv_t;

    typedef struct {
        outv_t o;
        logic  z;
        logic  r;
    } cyc_t;

    typedef enum int {
        M_ADD, M_SUB, M_AND, M_OR, M_SLL, M_ADDI, M_ORI, M_SLTI,
        M_BEQ, M_BNE, M_LW, M_SW, M_J, M_JAL, M_JR, M_UNDEF
    } mn_t;

    cyc_t  tr[$];
    outv_t act;

    assign act = {state, halted, PCWre, IRWre, InsMemRW, RegWre, ExtSel, ALUSrcA, ALUSrcB,
                  mRD, mWR, DBDataSrc, WrRegDSrc, PCSrc, RegDst, ALUOp};

    multi_cycle_control_unit #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_EN(1)) dut (
        .CLK(CLK), .Reset(Reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre), .ExtSel(ExtSel),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .mRD(mRD), .mWR(mWR), .DBDataSrc(DBDataSrc),
        .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc), .RegDst(RegDst), .ALUOp(ALUOp),
        .state(state), .halted(halted)
    );

    always #5 CLK = ~CLK;

    function automatic outv_t blank(input logic [2:0] st);
        outv_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic outv_t if_out();
        outv_t o;
        o = blank(3'b000);
        o.irwre  = 1'b1;
        o.insmem = 1'b1;
        return o;
    endfunction

    function automatic logic [2:0] alu_of(input mn_t m);
        case (m)
            M_SUB:         return 3'b001;
            M_AND:         return 3'b100;
            M_OR, M_ORI:   return 3'b011;
            M_SLL:         return 3'b010;
            M_SLTI:        return 3'b101;
            default:       return 3'b000;
        endcase
    endfunction

    task automatic encode(input mn_t m);
        func = 6'($urandom);
        case (m)
            M_ADD:   begin op = 6'b000000; func = 6'b100000; end
            M_SUB:   begin op = 6'b000000; func = 6'b100010; end
            M_AND:   begin op = 6'b000000; func = 6'b100100; end
            M_OR:    begin op = 6'b000000; func = 6'b100101; end
            M_SLL:   begin op = 6'b000000; func = 6'b000000; end
            M_JR:    begin op = 6'b000000; func = 6'b001000; end
            M_ADDI:  op = 6'b001000;
            M_ORI:   op = 6'b001101;
            M_SLTI:  op = 6'b001010;
            M_BEQ:   op = 6'b000100;
            M_BNE:   op = 6'b000101;
            M_LW:    op = 6'b100011;
            M_SW:    op = 6'b101011;
            M_J:     op = 6'b000010;
            M_JAL:   op = 6'b000011;
            default: op = 6'b110011;
        endcase
    endtask

    task automatic push(input outv_t o, input logic z, input logic r);
        cyc_t c;
        c.o = o;
        c.z = z;
        c.r = r;
        tr.push_back(c);
    endtask

    // Expected per-cycle behaviour of one instruction, from its architectural meaning.
    task automatic build(input mn_t m, input logic z_exe, input int waits);
        outv_t o;
        bit is_imm, is_alu;
        is_imm = m inside {M_ADDI, M_ORI, M_SLTI};
        is_alu = m inside {M_ADD, M_SUB, M_AND, M_OR, M_SLL, M_ADDI, M_ORI, M_SLTI};
        tr.delete();
        push(if_out(), 1'($urandom), 1'($urandom));
        o = blank(3'b001);
        case (m)
            M_J:     begin o.pcwre = 1; o.pcsrc = 2'b10; end
            M_JAL:   begin o.pcwre = 1; o.pcsrc = 2'b10; o.regwre = 1; o.regdst = 2'b00; end
            M_JR:    begin o.pcwre = 1; o.pcsrc = 2'b11; end
            M_UNDEF: begin o.pcwre = 1; o.pcsrc = 2'b00; end
            default: ;
        endcase
        push(o, 1'($urandom), 1'($urandom));
        if (m inside {M_J, M_JAL, M_JR, M_UNDEF}) return;
        o = blank(3'b010);
        if (m inside {M_BEQ, M_BNE}) begin
            o.aluop = 3'b001;
            o.pcwre = 1;
            o.pcsrc = ((m == M_BEQ && z_exe) || (m == M_BNE && !z_exe)) ? 2'b01 : 2'b00;
        end else if (m inside {M_LW, M_SW}) begin
            o.extsel = 1;
            o.srcb   = 1;
        end else begin
            o.aluop  = alu_of(m);
            o.srca   = (m == M_SLL);
            o.srcb   = is_imm;
            o.extsel = m inside {M_ADDI, M_SLTI, M_SUB};
        end
        push(o, z_exe, 1'($urandom));
        if (m inside {M_BEQ, M_BNE}) return;
        if (m inside {M_LW, M_SW}) begin
            for (int i = 0; i <= waits; i++) begin
                o = blank(3'b011);
                o.mrd = (m == M_LW);
                o.mwr = (m == M_SW);
                if (i == waits && m == M_SW) o.pcwre = 1;
                push(o, 1'($urandom), (i == waits));
            end
            if (m == M_SW) return;
        end
        o = blank(3'b100);
        o.regwre = 1;
        o.pcwre  = 1;
        o.wrsrc  = 1;
        o.dbsrc  = (m == M_LW);
        o.regdst = (m == M_LW || is_imm) ? 2'b01 : 2'b10;
        if (is_alu || m == M_LW) push(o, 1'($urandom), 1'($urandom));
    endtask

    // Plays the first n expected cycles; starts and ends just after a rising edge.
    task automatic run(input string name, input int n);
        for (int i = 0; i < n && i < tr.size(); i++) begin
            zero      = tr[i].z;
            mem_ready = tr[i].r;
            @(negedge CLK);
            checks++;
            if (act !== tr[i].o) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h want %h", name, i, act, tr[i].o);
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_instr(input string name, input mn_t m, input logic z, input int waits);
        encode(m);
        build(m, z, waits);
        run(name, tr.size());
    endtask

    task automatic check_async_reset(input string name);
        #1 Reset = 1'b0;
        #1;
        checks++;
        if (act !== if_out()) begin
            errors++;
            $display("FAIL %s async: got %h want %h", name, act, if_out());
        end
        @(posedge CLK);
        #1 Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        encode(M_LW);
        for (int i = 0; i < 3; i++) begin
            zero      = 1'($urandom);
            mem_ready = 1'($urandom);
            @(negedge CLK);
            checks++;
            if (act !== if_out()) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h want %h", i, act, if_out());
            end
        end
        @(posedge CLK);
        #1 Reset = 1'b1;
    endtask

    task automatic test_addi();
        do_instr("addi", M_ADDI, 1'($urandom), 0);
    endtask

    task automatic test_branch();
        do_instr("beq_taken", M_BEQ, 1'b1, 0);
        do_instr("bne_zero", M_BNE, 1'b1, 0);
        do_instr("beq_not", M_BEQ, 1'b0, 0);
        do_instr("bne_taken", M_BNE, 1'b0, 0);
    endtask

    task automatic test_lw_wait();
        do_instr("lw_wait3", M_LW, 1'b0, 3);
        do_instr("sw_wait2", M_SW, 1'b0, 2);
    endtask

    task automatic test_jumps();
        do_instr("jal", M_JAL, 1'b0, 0);
        do_instr("j", M_J, 1'b0, 0);
        do_instr("jr", M_JR, 1'b0, 0);
    endtask

    task automatic test_undef();
        do_instr("undef", M_UNDEF, 1'b0, 0);
    endtask

    task automatic test_random();
        mn_t m;
        for (int k = 0; k < 60; k++) begin
            m = mn_t'($urandom_range(0, 15));
            do_instr($sformatf("rand%0d_%s", k, m.name()), m, 1'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_mid_mem_reset();
        encode(M_LW);
        build(M_LW, 1'b0, 5);
        run("lw_cut", 5);
        check_async_reset("mid_mem_reset");
        do_instr("after_mem_reset", M_ADD, 1'b0, 0);
    endtask

    task automatic test_halt();
        outv_t h;
        op   = 6'b111111;
        func = 6'($urandom);
        tr.delete();
        push(if_out(), 1'($urandom), 1'($urandom));
        push(blank(3'b001), 1'($urandom), 1'($urandom));
        h = blank(3'b111);
        h.halted = 1'b1;
        for (int i = 0; i < 10; i++) push(h, 1'($urandom), 1'($urandom));
        run("halt", tr.size());
        check_async_reset("halt_reset");
        do_instr("after_halt", M_ORI, 1'b0, 0);
    endtask

    initial begin
        Reset     = 1'b0;
        op        = '0;
        func      = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_addi();
        test_branch();
        test_lw_wait();
        test_jumps();
        test_undef();
        test_random();
        test_mid_mem_reset();
        test_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control_unit.md
MULTI_CYCLE_CONTROL_UNIT -- requirements
Module: multi_cycle_control_unit

Interface
REQ-001 Parameter OP_W, default 6, opcode/funct field width.
REQ-002 Parameter ALUOP_W, default 3, ALU operation select width.
REQ-003 Parameter MEM_WAIT_EN, default 1; when 1, MEM state honours mem_ready; when 0, mem_ready is treated as constant 1.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 Reset  in  1  asynchronous, active-low reset.
REQ-006 op, func  in  OP_W each  instruction opcode / funct from the externally latched IR, stable from ID onward.
REQ-007 zero  in  1  ALU result-equals-zero flag, sampled in EXE.
REQ-008 mem_ready  in  1  data memory done strobe, sampled in MEM.
REQ-009 PCWre, IRWre, InsMemRW, RegWre, ExtSel, ALUSrcA, ALUSrcB, mRD, mWR, DBDataSrc, WrRegDSrc  out  1 each  datapath strobes/selects (WrRegDSrc: 0 = PC+4, 1 = DB).
REQ-010 PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr).
REQ-011 RegDst  out  2  00 $31, 01 rt, 10 rd.
REQ-012 ALUOp  out  ALUOP_W  ALU function; state  out  3  current FSM state; halted  out  1.

Function
REQ-013 FSM states SHALL be IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111; other codes go to IF on the next edge.
REQ-014 IF: IRWre=1, InsMemRW=1; next state is always ID.
REQ-015 ID: j -> IF with PCWre=1, PCSrc=10; jal -> IF with PCWre=1, PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0; jr (op 000000, func 001000) -> IF with PCWre=1, PCSrc=11; halt (111111) -> HALT; defined ALU/branch/memory ops -> EXE; undefined op -> IF with PCWre=1, PCSrc=00 (NOP).
REQ-016 EXE, beq (000100)/bne (000101): ALUOp=001, PCWre=1, PCSrc=01 when (beq and zero) or (bne and not zero), else 00; next state IF.
REQ-017 EXE, lw (100011)/sw (101011): ExtSel=1, ALUSrcB=1, ALUOp=000; next state MEM.
REQ-018 EXE, ALU ops: add/sub/and/or/sll (funcs 100000/100010/100100/100101/000000) and addi/ori/slti (001000/001101/001010), ALUOp 000/001/100/011/010/000/011/101 respectively; ALUSrcA=1 only for sll; ALUSrcB=1 for immediates; ExtSel=1 for addi/slti/sub; next state WB.
REQ-019 MEM: mRD=1 (lw) or mWR=1 (sw) held every cycle while mem_ready=0; state holds; on mem_ready=1, lw -> WB, sw -> IF with PCWre=1, PCSrc=00.
REQ-020 WB: RegWre=1, PCWre=1, PCSrc=00, WrRegDSrc=1, DBDataSrc=1 for lw else 0, RegDst=01 for immediates/lw else 10; next state IF.
REQ-021 HALT: all strobes 0, halted=1, state held until Reset.
REQ-022 Outputs SHALL be combinational from state, op, func, zero, mem_ready only; every strobe not named for a state is 0 in that state.
REQ-023 PCWre and RegWre SHALL each be 1 in at most one state per instruction.
REQ-024 Instruction latency: jumps/jr/NOP 2 cycles, branch 3, ALU 4, sw 4+wait, lw 5+wait.

Reset
REQ-025 Reset low SHALL force state=IF immediately, independent of CLK, including mid-MEM or HALT.
REQ-026 While Reset low: IRWre=1, InsMemRW=1 (IF decode), all other strobes 0, halted=0.
REQ-027 First rising edge after Reset release moves IF -> ID.

Structure
REQ-028 Package mcu_pkg SHALL hold opcode/funct constants, state encodings, ALUOp codes and PCSrc/RegDst codes.
REQ-029 One sub-module mcu_decode SHALL classify op/func into instruction-class flags; FSM and output logic stay in the top.

Verification
REQ-030 Reset low, then addi (001000) -> states 000,001,010,100,000; RegWre=1 only in WB, ALUOp=000, ALUSrcB=1.
REQ-031 beq with zero=1 -> EXE shows PCSrc=01, PCWre=1; bne with zero=1 -> PCSrc=00, PCWre=1.
REQ-032 lw with mem_ready low 3 cycles -> MEM held 4 cycles, mRD=1 throughout, then WB with DBDataSrc=1, RegDst=01.
REQ-033 jal -> ID asserts PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0, next state IF.
REQ-034 halt -> state 111, halted=1, PCWre=0 for 10 cycles; Reset pulse low returns state to 000 asynchronously.
REQ-035 Undefined op 110011 -> 2-cycle NOP, RegWre and mWR never 1.
